// File: rtl/motor_pwm_monitor.sv
// motor_pwm_monitor: Avalon-MM read-only slave that measures the high time and period of PWM inputs.
//   clk           : system clock
//   reset         : synchronous active-high reset
//   pwm_in        : asynchronous PWM inputs, one per channel
//   read          : Avalon read strobe
//   addr          : [3:1] channel, [0] register select (0 = VALID/LEVEL/HIGH, 1 = PERIOD)
//   readdata      : registered read data, one cycle after read
//   readdatavalid : one-cycle pulse one cycle after read
module motor_pwm_monitor #(
    parameter int NUM_CH  = 6,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] pwm_in,
    input  logic              read,
    input  logic [3:0]        addr,
    output logic [31:0]       readdata,
    output logic              readdatavalid
);
    typedef enum logic {IDLE, MEASURE} state_t;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    logic [NUM_CH-1:0] meta_q, s_q, s_dly_q, rise;
    logic [31:0]       stat_w [8];
    logic [31:0]       per_w  [8];
    logic [2:0]        ch;
    logic [31:0]       rd_word;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q  <= '0;
            s_q     <= '0;
            s_dly_q <= '0;
        end else begin
            meta_q  <= pwm_in;
            s_q     <= meta_q;
            s_dly_q <= s_q;
        end
    end

    assign rise = s_q & ~s_dly_q;

    for (genvar c = 0; c < 8; c++) begin : g_ch
        if (c < NUM_CH) begin : g_on
            state_t           state_q, state_d;
            logic [CNT_W-1:0] per_cnt_q, per_cnt_d, hi_cnt_q, hi_cnt_d;
            logic [CNT_W-1:0] high_q, high_d, period_q, period_d;
            logic             valid_q, valid_d, level_q, level_d;

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_q   <= IDLE;
                    per_cnt_q <= '0;
                    hi_cnt_q  <= '0;
                    high_q    <= '0;
                    period_q  <= '0;
                    valid_q   <= 1'b0;
                    level_q   <= 1'b0;
                end else begin
                    state_q   <= state_d;
                    per_cnt_q <= per_cnt_d;
                    hi_cnt_q  <= hi_cnt_d;
                    high_q    <= high_d;
                    period_q  <= period_d;
                    valid_q   <= valid_d;
                    level_q   <= level_d;
                end
            end

            // Counters default to clear; only a non-edge, non-timeout MEASURE cycle advances them.
            // The +1 on latch accounts for the edge cycle itself, which is high.
            always_comb begin
                state_d   = state_q;
                per_cnt_d = '0;
                hi_cnt_d  = '0;
                high_d    = high_q;
                period_d  = period_q;
                valid_d   = valid_q;
                level_d   = level_q;
                if (state_q == IDLE) begin
                    if (rise[c]) state_d = MEASURE;
                end else if (rise[c]) begin
                    high_d   = sat_inc(hi_cnt_q);
                    period_d = sat_inc(per_cnt_q);
                    valid_d  = 1'b1;
                end else if (per_cnt_q == TO_VAL) begin
                    high_d   = '0;
                    period_d = '0;
                    valid_d  = 1'b0;
                    level_d  = s_q[c];
                    state_d  = IDLE;
                end else begin
                    per_cnt_d = sat_inc(per_cnt_q);
                    hi_cnt_d  = s_q[c] ? sat_inc(hi_cnt_q) : hi_cnt_q;
                end
            end

            assign stat_w[c] = {valid_q, level_q, 30'(high_q)};
            assign per_w[c]  = 32'(period_q);
        end else begin : g_off
            assign stat_w[c] = '0;
            assign per_w[c]  = '0;
        end
    end

    assign ch      = addr[3:1];
    assign rd_word = addr[0] ? per_w[ch] : stat_w[ch];

    always_ff @(posedge clk) begin
        if (reset) begin
            readdata      <= '0;
            readdatavalid <= 1'b0;
        end else begin
            readdatavalid <= read;
            if (read) readdata <= rd_word;
        end
    end
endmodule

// File: tb/tb_motor_pwm_monitor.sv
// tb_motor_pwm_monitor: scoreboard bench for motor_pwm_monitor (main instance plus a CNT_W=8 instance).
module tb_motor_pwm_monitor;
    logic        clk, reset, rst_b;
    logic        read_a, read_b, rdv_a, rdv_b;
    logic [3:0]  addr_a, addr_b;
    logic [31:0] rdata_a, rdata_b;
    logic [6:0]  pwm;

    int vectors = 0;
    int miscompares = 0;
    int tk = 0;
    int mode [7];
    int hi [7];
    int per [7];
    int ph [7];
    int rise_tk [7];
    logic [31:0] qa [$];
    logic [31:0] qb [$];
    logic [31:0] last_a = '0, last_b = '0;
    logic        seen_a = 0, seen_b = 0, rst_seen_a = 0, rst_seen_b = 0;
    bit          mon_on = 0;

    motor_pwm_monitor #(.NUM_CH(6), .CNT_W(16), .TIMEOUT(100)) u_a (
        .clk(clk), .reset(reset), .pwm_in(pwm[5:0]), .read(read_a), .addr(addr_a),
        .readdata(rdata_a), .readdatavalid(rdv_a));

    motor_pwm_monitor #(.NUM_CH(1), .CNT_W(8), .TIMEOUT(255)) u_b (
        .clk(clk), .reset(rst_b), .pwm_in(pwm[6:6]), .read(read_b), .addr(addr_b),
        .readdata(rdata_b), .readdatavalid(rdv_b));

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: sim time exceeded, vectors=%0d", vectors);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @tick %0d: got %h expected %h", tag, tk, got, exp);
        end
    endtask

    always @(posedge clk) begin
        seen_a     <= read_a & ~reset;
        seen_b     <= read_b & ~rst_b;
        rst_seen_a <= reset;
        rst_seen_b <= rst_b;
    end

    always @(negedge clk) begin
        if (mon_on) begin
            if (rst_seen_a) last_a = '0;
            if (rst_seen_b) last_b = '0;
            chk("rdv_a", 32'(rdv_a), 32'(seen_a));
            chk("rdv_b", 32'(rdv_b), 32'(seen_b));
            if (rdv_a && qa.size() > 0) begin
                chk("data_a", rdata_a, qa.pop_front());
                last_a = rdata_a;
            end else if (!rdv_a) chk("hold_a", rdata_a, last_a);
            if (rdv_b && qb.size() > 0) begin
                chk("data_b", rdata_b, qb.pop_front());
                last_b = rdata_b;
            end else if (!rdv_b) chk("hold_b", rdata_b, last_b);
        end
    end

    task automatic tick();
        bit nv;
        @(negedge clk);
        tk++;
        read_a = 0;
        read_b = 0;
        for (int c = 0; c < 7; c++) begin
            nv = (mode[c] == 2) ? (ph[c] < hi[c]) : (mode[c] == 1);
            if (mode[c] == 2) ph[c] = (ph[c] + 1 == per[c]) ? 0 : ph[c] + 1;
            if (nv && !pwm[c]) rise_tk[c] = tk;
            pwm[c] = nv;
        end
    endtask

    task automatic rd(input bit b, input logic [3:0] a, input logic [31:0] e);
        tick();
        if (b) begin
            read_b = 1;
            addr_b = a;
            qb.push_back(e);
        end else begin
            read_a = 1;
            addr_a = a;
            qa.push_back(e);
        end
    endtask

    task automatic rd_at(input int j, input bit b, input logic [3:0] a, input logic [31:0] e);
        while (tk < j - 1) tick();
        rd(b, a, e);
    endtask

    task automatic start(input int c, input int h, input int p, input int ph0);
        mode[c] = 2;
        hi[c]   = h;
        per[c]  = p;
        ph[c]   = ph0;
    endtask

    initial begin
        int s1, s2, e0, e5, r5, rt, f0, sb;
        reset = 1; rst_b = 1; read_a = 0; read_b = 0; addr_a = '0; addr_b = '0; pwm = '0;
        for (int c = 0; c < 7; c++) begin
            mode[c] = 0; hi[c] = 0; per[c] = 1; ph[c] = 0; rise_tk[c] = -1;
        end
        repeat (3) tick();
        reset = 0;
        rst_b = 0;
        mon_on = 1;

        for (int a = 0; a < 16; a++) rd(0, 4'(a), 32'h0);
        rd(1, 4'd0, 32'h0);
        rd(1, 4'd1, 32'h0);

        start(0, 8, 32, 0);
        start(5, 8, 32, 0);
        start(6, 100, 255, 0);
        sb = tk + 1;

        // 25% duty on ch2: nothing valid until the second rising edge has been processed
        start(2, 8, 32, 0);
        s2 = tk + 1;
        rd_at(s2 + 10, 0, 4'd4, 32'h0);
        rd_at(s2 + 34, 0, 4'd4, 32'h0);
        rd_at(s2 + 35, 0, 4'd4, 32'h8000_0008);
        rd_at(s2 + 130, 0, 4'd4, 32'h8000_0008);
        rd(0, 4'd5, 32'h20);

        // ch0 duty switches 8 -> 24 at a period boundary; every read is old or new, never in between
        tick();
        while (rise_tk[0] != tk) tick();
        e0 = tk;
        hi[0] = 24;
        for (int j = e0 + 1; j <= e0 + 45; j++)
            rd_at(j, 0, 4'd0, (j <= e0 + 34) ? 32'h8000_0008 : 32'h8000_0018);
        rd(0, 4'd1, 32'd32);

        // ch1: read on the exact latch cycle returns old values, next cycle returns new
        start(1, 5, 20, 0);
        s1 = tk + 1;
        while (tk < s1 + 20) tick();
        hi[1] = 10;
        rd_at(s1 + 22, 0, 4'd2, 32'h0);
        rd_at(s1 + 23, 0, 4'd2, 32'h8000_0005);
        rd_at(s1 + 24, 0, 4'd3, 32'd20);
        rd_at(s1 + 42, 0, 4'd2, 32'h8000_0005);
        rd_at(s1 + 43, 0, 4'd2, 32'h8000_000A);
        rd(0, 4'd14, 32'h0);
        rd(0, 4'd15, 32'h0);
        rd(0, 4'd6, 32'h0);

        // ch5 stalls high: timeout exactly when per_cnt reaches TIMEOUT, then restart
        tick();
        while (rise_tk[5] != tk) tick();
        mode[5] = 1;
        e5 = tk;
        rd_at(e5 + 103, 0, 4'd10, 32'h8000_0008);
        rd_at(e5 + 104, 0, 4'd10, 32'h4000_0000);
        rd(0, 4'd11, 32'h0);
        start(5, 8, 32, 8);
        while (rise_tk[5] <= e5) tick();
        r5 = rise_tk[5];
        rd_at(r5 + 34, 0, 4'd10, 32'h4000_0000);
        rd_at(r5 + 35, 0, 4'd10, 32'hC000_0008);
        rd(0, 4'd11, 32'd32);

        // one-cycle reset mid-period on ch0 while its input is low
        mode[1] = 0; mode[2] = 0; mode[5] = 0;
        tick();
        while (ph[0] != 26) tick();
        reset = 1;
        rt = tk;
        tick();
        reset = 0;
        for (int a = 0; a < 12; a++) rd(0, 4'(a), 32'h0);
        while (rise_tk[0] <= rt) tick();
        f0 = rise_tk[0];
        rd_at(f0 + 34, 0, 4'd0, 32'h0);
        rd_at(f0 + 35, 0, 4'd0, 32'h8000_0018);
        rd(0, 4'd1, 32'd32);

        // CNT_W=8 instance: a 255-cycle period must read back as 255
        while (tk < sb + 600) tick();
        rd(1, 4'd0, 32'h8000_0064);
        rd(1, 4'd1, 32'h0000_00FF);
        rd(1, 4'd2, 32'h0);
        rd(1, 4'd15, 32'h0);

        repeat (3) tick();
        chk("qa_drain", qa.size(), 32'd0);
        chk("qb_drain", qb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
